// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the two-requester ALU arbiter:
//   - alu_op_t      : 3-bit opcode type
//   - ALU_ADD..XNOR : opcode encodings (every 3-bit code is a defined op)
//   - alu_state_t   : control FSM states (IDLE, EXEC, RESP)
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_ADD  = 3'b000;
   localparam alu_op_t ALU_SUB  = 3'b001;
   localparam alu_op_t ALU_MUL  = 3'b010;
   localparam alu_op_t ALU_AND  = 3'b011;
   localparam alu_op_t ALU_OR   = 3'b100;
   localparam alu_op_t ALU_NOT  = 3'b101;
   localparam alu_op_t ALU_XOR  = 3'b110;
   localparam alu_op_t ALU_XNOR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// ---------------------------------------------------------------------------
// alu_rr_arb2
//   Two-way round-robin grant. The priority pointer names the requester that
//   wins when both are valid; after every accepted command it moves to the
//   requester that did not win.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointer resets to 0)
//   valid0/1     request lines
//   accept       the current grant was taken this cycle
//   grant        id of the requester currently granted
// ---------------------------------------------------------------------------
module alu_rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic grant
);

   logic prio;

   // A lone requester always wins; with no requester the pointer is
   // presented, which is harmless because no handshake can happen.
   always_comb begin
      grant = prio;
      if (valid0 && valid1) begin
         grant = prio;
      end else if (valid1) begin
         grant = 1'b1;
      end else if (valid0) begin
         grant = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (accept) begin
         prio <= ~grant;
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one DATA_W-bit, 8-opcode ALU between two valid/ready requesters.
//   Round-robin arbitration picks a command in IDLE, the operands are latched,
//   the op executes in EXEC, and the registered result (tagged with the
//   requester id) is offered on a valid/ready response port in RESP.
// Parameters:
//   DATA_W          operand width; results are 2*DATA_W bits
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req0_* / req1_* valid, ready, a, b, op per requester
//   rsp_valid/ready response handshake
//   rsp_id          requester that issued the result
//   rsp_data        result
//   busy            FSM is not in IDLE
//   stat_gnt0/1     saturating accept counters (only with ALU_ARB_STATS_EN)
// Configuration macro: ALU_ARB_STATS_EN
// ---------------------------------------------------------------------------
module alu_req_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [DATA_W-1:0]   req0_a,
   input  logic [DATA_W-1:0]   req0_b,
   input  logic [2:0]          req0_op,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [DATA_W-1:0]   req1_a,
   input  logic [DATA_W-1:0]   req1_b,
   input  logic [2:0]          req1_op,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [2*DATA_W-1:0] rsp_data,
`ifdef ALU_ARB_STATS_EN
   output logic [15:0]         stat_gnt0,
   output logic [15:0]         stat_gnt1,
`endif
   output logic                busy
);

   localparam int RES_W = 2 * DATA_W;

   alu_state_t         state;
   alu_state_t         state_next;
   logic               grant;
   logic               accept;
   logic [DATA_W-1:0]  a_q;
   logic [DATA_W-1:0]  b_q;
   alu_op_t            op_q;
   logic               id_q;
   logic [RES_W-1:0]   a_ext;
   logic [RES_W-1:0]   b_ext;
   logic [RES_W-1:0]   alu_res;

   alu_rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .accept (accept),
      .grant  (grant)
   );

   // Ready is gated by rst_n so both readies read 0 while reset is held.
   assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
   assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
   assign accept     = req0_ready || req1_ready;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);

   // Operands are zero-extended first so sub wraps, mul keeps the full
   // product and not/xnor set the upper result bits.
   always_comb begin
      a_ext   = {{DATA_W{1'b0}}, a_q};
      b_ext   = {{DATA_W{1'b0}}, b_q};
      alu_res = '0;
      case (op_q)
         ALU_ADD:  alu_res = a_ext + b_ext;
         ALU_SUB:  alu_res = a_ext - b_ext;
         ALU_MUL:  alu_res = a_ext * b_ext;
         ALU_AND:  alu_res = a_ext & b_ext;
         ALU_OR:   alu_res = a_ext | b_ext;
         ALU_NOT:  alu_res = ~a_ext;
         ALU_XOR:  alu_res = a_ext ^ b_ext;
         ALU_XNOR: alu_res = ~(a_ext ^ b_ext);
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The winning command is captured on the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= ALU_ADD;
         id_q <= 1'b0;
      end else if (accept) begin
         a_q  <= grant ? req1_a  : req0_a;
         b_q  <= grant ? req1_b  : req0_b;
         op_q <= grant ? req1_op : req0_op;
         id_q <= grant;
      end
   end

   // Result is registered at the end of EXEC and held through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_id   <= 1'b0;
      end else if (state == EXEC) begin
         rsp_data <= alu_res;
         rsp_id   <= id_q;
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [15:0] stat_cnt0;
   logic [15:0] stat_cnt1;

   // Accept counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt0 <= '0;
         stat_cnt1 <= '0;
      end else begin
         if (req0_ready && (stat_cnt0 != 16'hFFFF)) stat_cnt0 <= stat_cnt0 + 16'd1;
         if (req1_ready && (stat_cnt1 != 16'hFFFF)) stat_cnt1 <= stat_cnt1 + 16'd1;
      end
   end

   assign stat_gnt0 = stat_cnt0;
   assign stat_gnt1 = stat_cnt1;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_req_arbiter
//   Self-checking bench for alu_req_arbiter (DATA_W = 4). A cycle-level
//   reference (phase counter, priority bit, arithmetic result function) is
//   compared against the DUT every cycle; directed sequences add literal
//   expectations. Build with ALU_ARB_STATS_EN to exercise the counters.
// ---------------------------------------------------------------------------
module tb_alu_req_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v0 = 1'b0, v1 = 1'b0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [2:0] op0 = '0, op1 = '0;
   logic       rsp_ready = 1'b0;
   logic       r0, r1, rsp_valid, rsp_id, busy;
   logic [7:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1;
`endif

   alu_req_arbiter #(.DATA_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0),
      .req0_ready (r0),
      .req0_a     (a0),
      .req0_b     (b0),
      .req0_op    (op0),
      .req1_valid (v1),
      .req1_ready (r1),
      .req1_a     (a1),
      .req1_b     (b1),
      .req1_op    (op1),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
`ifdef ALU_ARB_STATS_EN
      .stat_gnt0  (stat_gnt0),
      .stat_gnt1  (stat_gnt1),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: phase 0 idle, 1 executing, 2 responding.
   int m_phase = 0;
   int m_prio  = 0;
   int m_data  = 0;
   int m_id    = 0;
   bit m_acc0  = 0, m_acc1 = 0;
   int m_cnt0  = 0, m_cnt1 = 0;

   // Values sampled at the last negedge.
   logic       s_r0, s_r1, s_valid, s_id, s_busy;
   logic [7:0] s_data;
   int         order_q[$];

   function automatic int ref_alu(input int a, input int b, input int op);
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a * b;
         3: return a & b;
         4: return a | b;
         5: return 255 - a;
         6: return a ^ b;
         default: return 255 - (a ^ b);
      endcase
   endfunction

   function automatic int ref_grant();
      if (v0 && v1) return m_prio;
      if (v1) return 1;
      return 0;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_output();
      int g;
      g = ref_grant();
      s_r0 = r0; s_r1 = r1; s_valid = rsp_valid; s_id = rsp_id;
      s_busy = busy; s_data = rsp_data;
      if (r0) order_q.push_back(0);
      if (r1) order_q.push_back(1);
      cmp("busy", busy, m_phase != 0);
      cmp("rsp_valid", rsp_valid, m_phase == 2);
      cmp("req0_ready", r0, (m_phase == 0) && v0 && (g == 0));
      cmp("req1_ready", r1, (m_phase == 0) && v1 && (g == 1));
      if (m_phase == 2) begin
         cmp("rsp_data", rsp_data, m_data);
         cmp("rsp_id", rsp_id, m_id);
      end
`ifdef ALU_ARB_STATS_EN
      cmp("stat_gnt0", stat_gnt0, m_cnt0);
      cmp("stat_gnt1", stat_gnt1, m_cnt1);
`endif
   endtask

   task automatic update_model();
      int g;
      g = ref_grant();
      m_acc0 = (m_phase == 0) && v0 && (g == 0);
      m_acc1 = (m_phase == 0) && v1 && (g == 1);
      if (m_acc0 || m_acc1) begin
         m_id    = m_acc1 ? 1 : 0;
         m_data  = m_acc1 ? ref_alu(a1, b1, op1) : ref_alu(a0, b0, op0);
         m_prio  = 1 - m_id;
         m_phase = 1;
         if (m_acc0 && m_cnt0 < 65535) m_cnt0++;
         if (m_acc1 && m_cnt1 < 65535) m_cnt1++;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
         m_phase = 0;
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_prio = 0; m_acc0 = 0; m_acc1 = 0;
      m_cnt0 = 0; m_cnt1 = 0;
   endtask

   // One clock: check at negedge, advance model at posedge, retire accepted
   // commands just after the edge.
   task automatic step();
      @(negedge clk);
      check_output();
      @(posedge clk);
      update_model();
      #1;
      if (m_acc0) v0 = 1'b0;
      if (m_acc1) v1 = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      model_reset();
      @(negedge clk);
      cmp("rst_busy", busy, 0);
      cmp("rst_rsp_valid", rsp_valid, 0);
      cmp("rst_rsp_data", rsp_data, 0);
      cmp("rst_rsp_id", rsp_id, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_rsp(input string name, input int exp_data, input int exp_id);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_valid && n < 12);
      cmp({name, "_seen"}, s_valid, 1);
      cmp({name, "_data"}, s_data, exp_data);
      cmp({name, "_id"}, s_id, exp_id);
   endtask

   task automatic do_op(input int id, input int a, input int b, input int op);
      if (id == 0) begin
         v0 = 1'b1; a0 = 4'(a); b0 = 4'(b); op0 = 3'(op);
      end else begin
         v1 = 1'b1; a1 = 4'(a); b1 = 4'(b); op1 = 3'(op);
      end
      wait_rsp("op", ref_alu(a, b, op), id);
      step();
   endtask

   task automatic apply_stimulus();
      if (!v0 && $urandom_range(0, 2) == 0) begin
         v0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom);
      end else if (v0 && m_phase != 0 && $urandom_range(0, 15) == 0) begin
         v0 = 1'b0;
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
         v1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom);
      end else if (v1 && m_phase != 0 && $urandom_range(0, 15) == 0) begin
         v1 = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      int exp_order[6];
      int n;
      exp_order = '{0, 1, 0, 1, 0, 1};

      // Reset then sub 3-5 on requester 0.
      rsp_ready = 1'b1;
      apply_reset();
      v0 = 1'b1; a0 = 4'd3; b0 = 4'd5; op0 = 3'b001;
      step();
      cmp("t1_ready0", s_r0, 1);
      step();
      cmp("t1_exec_valid", s_valid, 0);
      step();
      cmp("t1_valid", s_valid, 1);
      cmp("t1_data", s_data, 8'hFE);
      cmp("t1_id", s_id, 0);

      // Both valid from reset: req0 wins first.
      apply_reset();
      v0 = 1'b1; a0 = 4'd15; b0 = 4'd15; op0 = 3'b010;
      v1 = 1'b1; a1 = 4'd3;  b1 = 4'd0;  op1 = 3'b101;
      wait_rsp("t2_first", 8'hE1, 0);
      wait_rsp("t2_second", 8'hFC, 1);

      // Six accepts with both always valid alternate strictly.
      apply_reset();
      order_q.delete();
      v0 = 1'b1; v1 = 1'b1;
      n = 0;
      while (order_q.size() < 6 && n < 60) begin
         step();
         n++;
         if (!v0) begin v0 = 1'b1; a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom); end
         if (!v1) begin v1 = 1'b1; a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom); end
      end
      cmp("t3_count", order_q.size() >= 6, 1);
      for (int i = 0; i < 6; i++) begin
         if (i < order_q.size()) cmp("t3_order", order_q[i], exp_order[i]);
      end

      // Backpressure: response held for 5 cycles.
      apply_reset();
      rsp_ready = 1'b0;
      v0 = 1'b1; a0 = 4'd9; b0 = 4'd7; op0 = 3'b000;
      v1 = 1'b1; a1 = 4'd1; b1 = 4'd1; op1 = 3'b000;
      wait_rsp("t4", 8'h10, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         cmp("t4_hold_valid", s_valid, 1);
         cmp("t4_hold_data", s_data, 8'h10);
         cmp("t4_hold_id", s_id, 0);
         cmp("t4_no_ready1", s_r1, 0);
      end
      rsp_ready = 1'b1;
      step();
      step();
      cmp("t4_ready1_after", s_r1, 1);

      // Reset in EXEC discards the in-flight command.
      apply_reset();
      v1 = 1'b1; a1 = 4'd6; b1 = 4'd2; op1 = 3'b010;
      step();
      cmp("t5_accept", s_r1, 1);
      v1 = 1'b1; a1 = 4'd5; b1 = 4'd10; op1 = 3'b100;
      rst_n = 1'b0;
      #1;
      cmp("t5_busy", busy, 0);
      cmp("t5_rsp_valid", rsp_valid, 0);
      cmp("t5_ready0", r0, 0);
      cmp("t5_ready1", r1, 0);
      cmp("t5_data", rsp_data, 0);
      cmp("t5_id", rsp_id, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_rsp("t5_new", 8'h0F, 1);

      // Randomised traffic against the reference.
      for (int i = 0; i < 400; i++) begin
         apply_stimulus();
         step();
      end

`ifdef ALU_ARB_STATS_EN
      apply_reset();
      rsp_ready = 1'b1;
      do_op(0, 1, 2, 0);
      do_op(0, 3, 4, 1);
      do_op(1, 5, 6, 2);
      do_op(0, 7, 8, 3);
      step();
      cmp("t6_gnt0", stat_gnt0, 16'd3);
      cmp("t6_gnt1", stat_gnt1, 16'd1);
      force dut.stat_cnt0 = 16'hFFFF;
      #1 release dut.stat_cnt0;
      m_cnt0 = 65535;
      do_op(0, 2, 2, 6);
      cmp("t6_sat", stat_gnt0, 16'hFFFF);
`else
      do_op(0, 2, 3, 7);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
